reverser_req_scheduler: RTL

Sequences and shares the 4-bit bit-reversal datapath between two independent requesters. Each requester offers operands A, B and a select with a valid/ready handshake. The block arbitrates round-robin, registers the winning operands, and drives them through an internal instance of the existing reverser and 4-bit 2:1 mux datapath. It presents the registered result on a valid/ready output port with back-pressure. It sits between the ALSU operation decoder's request sources and the result bus.

---
 rtl/reverser_req_scheduler.sv | 125 ++++++++++++
 1 files changed

// File: rtl/reverser_req_scheduler.sv
// Round-robin scheduler that shares one 4-bit bit-reversal datapath between two
// valid/ready requesters and presents a registered result with back-pressure.

module reverser4 (
  input  logic [3:0] x_i,
  output logic [3:0] y_o
);
  assign y_o = {x_i[0], x_i[1], x_i[2], x_i[3]};
endmodule

module mux2x4 (
  input  logic [3:0] in0_i,
  input  logic [3:0] in1_i,
  input  logic       sel_i,
  output logic [3:0] y_o
);
  assign y_o = sel_i ? in1_i : in0_i;
endmodule

module reverser_req_scheduler #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_A,
  input  logic [3:0]       req0_B,
  input  logic             req0_Sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_A,
  input  logic [3:0]       req1_B,
  input  logic             req1_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       Out,
  output logic             out_src,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       opA_q;
  logic [3:0]       opB_q;
  logic             opSel_q;
  logic             opSrc_q;
  logic             lastGrant_q;
  logic             outValid_q;
  logic [3:0]       out_q;
  logic             outSrc_q;
  logic [CNT_W-1:0] opCount_q;

  logic       canAccept;
  logic       grant0;
  logic       grant1;
  logic [3:0] revA;
  logic [3:0] revB;
  logic [3:0] result;

  // The requester that did not win last time gets priority under contention.
  assign canAccept = (state_q == IDLE) && !rst;
  assign grant0 = canAccept && req0_valid && (!req1_valid || lastGrant_q);
  assign grant1 = canAccept && req1_valid && (!req0_valid || !lastGrant_q);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  reverser4 uRevA (.x_i(opA_q), .y_o(revA));
  reverser4 uRevB (.x_i(opB_q), .y_o(revB));
  mux2x4    uMux  (.in0_i(revA), .in1_i(revB), .sel_i(opSel_q), .y_o(result));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      opA_q       <= 4'b0000;
      opB_q       <= 4'b0000;
      opSel_q     <= 1'b0;
      opSrc_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      outValid_q  <= 1'b0;
      out_q       <= 4'b0000;
      outSrc_q    <= 1'b0;
      opCount_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            opA_q       <= grant1 ? req1_A : req0_A;
            opB_q       <= grant1 ? req1_B : req0_B;
            opSel_q     <= grant1 ? req1_Sel : req0_Sel;
            opSrc_q     <= grant1;
            lastGrant_q <= grant1;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          out_q      <= result;
          outSrc_q   <= opSrc_q;
          outValid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            opCount_q  <= opCount_q + CNT_W'(1);
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = outValid_q;
  assign Out       = out_q;
  assign out_src   = outSrc_q;
  assign op_count  = opCount_q;

endmodule
